// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage that sits directly after the program counter. It
// issues in-order fetch requests for pc_i and records each request's PC in a
// small circular buffer. Responses fill the buffer in order. Decode receives
// instructions, together with their PCs, in program order. A redirect
// (flush) empties the buffer. Responses that are still in flight at that
// point are counted and discarded when they arrive.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both high in that cycle. Once valid is raised it does not depend on
// the matching ready. The memory response channel has no ready signal. Each
// response pulse is one in-order response, and the memory must never send a
// response without a matching accepted request.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pc_i                current PC from the program counter
//   pc_advance          pulses for one cycle per accepted request
//   flush               redirect; discards buffered and in-flight fetches
//   imem_req_valid/ready/addr   fetch request channel to instruction memory
//   imem_rsp_valid/data         in-order response channel (no backpressure)
//   instr_valid/instr/instr_pc  head of the buffer offered to decode
//   decode_ready        decode consumes the head entry
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_advance,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             decode_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    head, tail, fill;
  logic [CW-1:0]    count, out_cnt, drop_cnt;
  logic [DEPTH-1:0] filled;
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic accept, pop, rsp_keep, rsp_drop;

  // Request eligibility uses only registered counters. A pop in this cycle
  // therefore does not re-enable the request until the next cycle. This
  // keeps decode_ready out of the request path. rst_n holds the request low
  // while reset is asserted.
  assign imem_req_valid = rst_n && !flush && (count < FULL) && (out_cnt < FULL);
  assign imem_req_addr  = pc_i;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  assign instr_valid = filled[head] && (count != '0);
  // Data fields are not reset. Masking with instr_valid makes the outputs
  // read 0 whenever nothing is being offered, including during reset.
  assign instr       = instr_valid ? instr_mem[head] : '0;
  assign instr_pc    = instr_valid ? pc_mem[head]    : '0;

  assign pop      = instr_valid && decode_ready && !flush;
  // A response belongs to a pre-flush request while drop_cnt is non-zero.
  // A response in the flush cycle itself is also discarded.
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      filled   <= '0;
      // No request is accepted during a flush. Every response still owed
      // after this cycle belongs to the old stream and must be dropped.
      out_cnt  <= out_cnt - CW'(imem_rsp_valid);
      drop_cnt <= out_cnt - CW'(imem_rsp_valid);
    end else begin
      if (accept)   tail <= tail + PW'(1);
      if (pop)      head <= head + PW'(1);
      if (rsp_keep) fill <= fill + PW'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      count   <= count + CW'(accept) - CW'(pop);
      out_cnt <= out_cnt + CW'(accept) - CW'(imem_rsp_valid);
      // The pop index (filled head) and the fill index (unfilled entry)
      // never coincide, so both updates can happen in the same cycle.
      if (pop)      filled[head] <= 1'b0;
      if (rsp_keep) filled[fill] <= 1'b1;
    end
  end

  // Payload storage. Written only on accept or kept response, and never reset.
  always_ff @(posedge clk) begin
    if (accept)   pc_mem[tail]    <= pc_i;
    if (rsp_keep) instr_mem[fill] <= imem_rsp_data;
  end

endmodule
